// File: rtl/adc_pkg.sv
// Shared constants for the dual-channel ADC averager: data width, command codes,
// channel addresses and FSM state encodings.
package adc_pkg;

  localparam int ADC_BITS = 14;

  localparam logic [3:0] OP_SEL  = 4'b0000;
  localparam logic [3:0] OP_RST  = 4'b0001;
  localparam logic [3:0] OP_CONV = 4'b0010;

  localparam logic [7:0] ADDR_A = 8'd0;
  localparam logic [7:0] ADDR_B = 8'd1;

  // State codes are plain constants so older blocks can share the encoding.
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_TRIG    = 4'd1;
  localparam state_t S_WAIT_LO = 4'd2;
  localparam state_t S_WAIT_HI = 4'd3;
  localparam state_t S_SEL_A   = 4'd4;
  localparam state_t S_CAP_A   = 4'd5;
  localparam state_t S_SEL_B   = 4'd6;
  localparam state_t S_CAP_B   = 4'd7;
  localparam state_t S_DONE    = 4'd8;
  localparam state_t S_ARST    = 4'd9;

endpackage

// File: rtl/adc_sample_averager_if.sv
// Command/response bus between the averager (master) and the dual-channel ADC interface (slave).
interface adc_sample_averager_if;
  import adc_pkg::*;

  logic                cs;
  logic [3:0]          op;
  logic [7:0]          addr;
  logic                rdy;
  logic [ADC_BITS-1:0] data;

  modport master (output cs, op, addr, input rdy, data);
  modport slave  (input cs, op, addr, output rdy, data);

endinterface

// File: rtl/adc_acc_channel.sv
// One channel's burst accumulator; with ADC_MINMAX_EN it also tracks the burst min/max sample.
module adc_acc_channel
  import adc_pkg::*;
#(
  parameter int SUM_W = ADC_BITS + 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                capture,
  input  logic [ADC_BITS-1:0] sample,
  output logic [SUM_W-1:0]    sum
`ifdef ADC_MINMAX_EN
  ,
  output logic [ADC_BITS-1:0] min_val,
  output logic [ADC_BITS-1:0] max_val
`endif
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (capture) begin
      sum <= sum + SUM_W'(sample);
    end
  end

`ifdef ADC_MINMAX_EN
  // Min starts at full scale so the first captured sample always replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_val <= '0;
      max_val <= '0;
    end else if (clear) begin
      min_val <= '1;
      max_val <= '0;
    end else if (capture) begin
      if (sample < min_val) min_val <= sample;
      if (sample > max_val) max_val <= sample;
    end
  end
`endif

endmodule

// File: rtl/adc_sample_averager.sv
// Runs 2^avg_shift ADC conversions, reads channels A and B after each and reports the averages.
// Optional per-burst min/max outputs are enabled by defining ADC_MINMAX_EN.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int MAX_SHIFT = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           avg_shift,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ADC_BITS-1:0]  res_a,
  output logic [ADC_BITS-1:0]  res_b,
`ifdef ADC_MINMAX_EN
  output logic [ADC_BITS-1:0]  res_min_a,
  output logic [ADC_BITS-1:0]  res_max_a,
  output logic [ADC_BITS-1:0]  res_min_b,
  output logic [ADC_BITS-1:0]  res_max_b,
`endif
  adc_sample_averager_if.master adc
);

  localparam int SUM_W   = ADC_BITS + MAX_SHIFT;
  localparam int CNT_W   = MAX_SHIFT + 1;
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_t             state, next_state;
  logic [3:0]         shift;
  logic [CNT_W-1:0]   count;
  logic [TIMER_W-1:0] timer;
  logic [SUM_W-1:0]   sum_a, sum_b;
  logic               start_ok, timed_out, last_sample;
  logic [CNT_W-1:0]   count_next;

  assign start_ok    = (state == S_IDLE) && start && !res_valid && adc.rdy;
  assign timed_out   = (timer == TIMER_W'(TIMEOUT));
  assign count_next  = count + 1'b1;
  assign last_sample = (count_next == (CNT_W'(1) << shift));
  assign busy        = (state != S_IDLE);

  // WAIT_LO must see rdy fall before WAIT_HI trusts a high rdy, so stale idle rdy is never sampled.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start_ok) next_state = S_TRIG;
      S_TRIG:    next_state = S_WAIT_LO;
      S_WAIT_LO: if (!adc.rdy) next_state = S_WAIT_HI;
                 else if (timed_out) next_state = S_ARST;
      S_WAIT_HI: if (adc.rdy) next_state = S_SEL_A;
                 else if (timed_out) next_state = S_ARST;
      S_SEL_A:   next_state = S_CAP_A;
      S_CAP_A:   next_state = S_SEL_B;
      S_SEL_B:   next_state = S_CAP_B;
      S_CAP_B:   next_state = last_sample ? S_DONE : S_TRIG;
      S_DONE:    next_state = S_IDLE;
      S_ARST:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
      shift <= '0;
      count <= '0;
    end else begin
      state <= next_state;
      timer <= (next_state != state || state == S_IDLE) ? '0 : timer + 1'b1;
      if (start_ok) begin
        shift <= (avg_shift > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : avg_shift;
        count <= '0;
      end else if (state == S_CAP_B) begin
        count <= count_next;
      end
    end
  end

  // Commands are decoded from next_state so cs is high exactly during the command state.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc.cs   <= 1'b0;
      adc.op   <= 4'b0000;
      adc.addr <= ADDR_A;
    end else begin
      adc.cs <= 1'b0;
      adc.op <= 4'b0000;
      case (next_state)
        S_TRIG:  begin adc.cs <= 1'b1; adc.op <= OP_CONV; end
        S_SEL_A: begin adc.cs <= 1'b1; adc.op <= OP_SEL; adc.addr <= ADDR_A; end
        S_SEL_B: begin adc.cs <= 1'b1; adc.op <= OP_SEL; adc.addr <= ADDR_B; end
        S_ARST:  begin adc.cs <= 1'b1; adc.op <= OP_RST; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      err       <= 1'b0;
    end else begin
      if (state == S_DONE) begin
        res_valid <= 1'b1;
        res_a     <= ADC_BITS'(sum_a >> shift);
        res_b     <= ADC_BITS'(sum_b >> shift);
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (state == S_ARST)  err <= 1'b1;
      else if (err_clr)     err <= 1'b0;
    end
  end

`ifdef ADC_MINMAX_EN
  logic [ADC_BITS-1:0] min_a, max_a, min_b, max_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_min_a <= '0;
      res_max_a <= '0;
      res_min_b <= '0;
      res_max_b <= '0;
    end else if (state == S_DONE) begin
      res_min_a <= min_a;
      res_max_a <= max_a;
      res_min_b <= min_b;
      res_max_b <= max_b;
    end
  end
`endif

  adc_acc_channel #(.SUM_W(SUM_W)) u_chan_a (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok),
    .capture (state == S_CAP_A),
    .sample  (adc.data),
    .sum     (sum_a)
`ifdef ADC_MINMAX_EN
    ,
    .min_val (min_a),
    .max_val (max_a)
`endif
  );

  adc_acc_channel #(.SUM_W(SUM_W)) u_chan_b (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok),
    .capture (state == S_CAP_B),
    .sample  (adc.data),
    .sum     (sum_b)
`ifdef ADC_MINMAX_EN
    ,
    .min_val (min_b),
    .max_val (max_b)
`endif
  );

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager with a small behavioural model of the dual-channel ADC.
module tb_adc_sample_averager;
  import adc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, err_clr, res_ready;
  logic [3:0]  avg_shift;
  logic        busy, err, res_valid;
  logic [13:0] res_a, res_b;
`ifdef ADC_MINMAX_EN
  logic [13:0] res_min_a, res_max_a, res_min_b, res_max_b;
`endif

  int checks = 0;
  int fails  = 0;

  adc_sample_averager_if adc ();

  adc_sample_averager dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .avg_shift (avg_shift),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_a     (res_a),
    .res_b     (res_b),
`ifdef ADC_MINMAX_EN
    .res_min_a (res_min_a),
    .res_max_a (res_max_a),
    .res_min_b (res_min_b),
    .res_max_b (res_max_b),
`endif
    .adc       (adc)
  );

  always #5 clk = ~clk;

  // ADC model: rdy drops for 3 cycles per conversion (forever when stuck); data follows the selected channel.
  logic [13:0] tbl_a [4];
  logic [13:0] tbl_b [4];
  logic        stuck = 1'b0;
  int          conv_base = 0;
  int          conv_cnt = 0;
  int          rst_cnt = 0;
  int          busy_cnt = 0;
  logic        rdy_r = 1'b1;
  logic [7:0]  chan = 8'd0;
  logic [13:0] cur_a = 14'd0, cur_b = 14'd0;

  always @(posedge clk) begin
    if (adc.cs && adc.op == OP_CONV) begin
      cur_a    <= tbl_a[(conv_cnt - conv_base) % 4];
      cur_b    <= tbl_b[(conv_cnt - conv_base) % 4];
      conv_cnt <= conv_cnt + 1;
      rdy_r    <= 1'b0;
      busy_cnt <= 3;
    end else if (adc.cs && adc.op == OP_RST) begin
      rst_cnt  <= rst_cnt + 1;
      rdy_r    <= 1'b1;
      busy_cnt <= 0;
    end else if (!rdy_r && !stuck) begin
      if (busy_cnt <= 1) rdy_r <= 1'b1;
      busy_cnt <= busy_cnt - 1;
    end
    if (adc.cs && adc.op == OP_SEL) chan <= adc.addr;
  end

  assign adc.rdy  = rdy_r;
  assign adc.data = (chan == ADDR_B) ? cur_b : cur_a;

  task automatic set_tables(input logic [13:0] a0, a1, a2, a3, b0, b1, b2, b3);
    tbl_a[0] = a0; tbl_a[1] = a1; tbl_a[2] = a2; tbl_a[3] = a3;
    tbl_b[0] = b0; tbl_b[1] = b1; tbl_b[2] = b2; tbl_b[3] = b3;
    conv_base = conv_cnt;
  endtask

  task automatic run_burst(input logic [3:0] sh, input int budget, output bit ok);
    ok = 1'b0;
    start = 1'b1; avg_shift = sh;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic consume;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; err_clr = 1'b0; res_ready = 1'b0; avg_shift = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", res_valid); end
    checks++; if ({res_a, res_b} !== 28'd0) begin fails++; $display("FAIL reset_res got %0d/%0d want 0/0", res_a, res_b); end
    checks++; if ({adc.cs, adc.op, adc.addr} !== 13'd0) begin fails++; $display("FAIL reset_adc got cs=%b op=%b addr=%0d want 0", adc.cs, adc.op, adc.addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok;
    int c0;
    set_tables(100, 100, 100, 100, 200, 200, 200, 200);
    c0 = conv_cnt;
    run_burst(4'd0, 200, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL single_done got valid=%b want 1", res_valid); end
    checks++; if (res_a !== 14'd100) begin fails++; $display("FAIL single_a got %0d want 100", res_a); end
    checks++; if (res_b !== 14'd200) begin fails++; $display("FAIL single_b got %0d want 200", res_b); end
    checks++; if (conv_cnt - c0 !== 1) begin fails++; $display("FAIL single_convs got %0d want 1", conv_cnt - c0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", busy); end
    consume();
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL single_accept got valid=%b want 0", res_valid); end
    checks++; if (res_a !== 14'd100) begin fails++; $display("FAIL single_hold got %0d want 100", res_a); end
  endtask

  task automatic test_average;
    bit ok;
    int c0;
    set_tables(10, 11, 12, 14, 20, 22, 24, 26);
    c0 = conv_cnt;
    run_burst(4'd2, 400, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL avg_done got valid=%b want 1", res_valid); end
    checks++; if (res_a !== 14'd11) begin fails++; $display("FAIL avg_a got %0d want 11", res_a); end
    checks++; if (res_b !== 14'd23) begin fails++; $display("FAIL avg_b got %0d want 23", res_b); end
    checks++; if (conv_cnt - c0 !== 4) begin fails++; $display("FAIL avg_convs got %0d want 4", conv_cnt - c0); end
`ifdef ADC_MINMAX_EN
    checks++; if ({res_min_a, res_max_a} !== {14'd10, 14'd14}) begin fails++; $display("FAIL minmax_a got %0d/%0d want 10/14", res_min_a, res_max_a); end
    checks++; if ({res_min_b, res_max_b} !== {14'd20, 14'd26}) begin fails++; $display("FAIL minmax_b got %0d/%0d want 20/26", res_min_b, res_max_b); end
`endif
    consume();
  endtask

  task automatic test_full_scale;
    bit ok;
    int c0;
    set_tables(16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383);
    for (int k = 0; k < 2; k++) begin
      c0 = conv_cnt;
      run_burst((k == 0) ? 4'd8 : 4'd12, 4000, ok);
      checks++; if (ok !== 1'b1) begin fails++; $display("FAIL full_done[%0d] got valid=%b want 1", k, res_valid); end
      checks++; if ({res_a, res_b} !== {14'd16383, 14'd16383}) begin fails++; $display("FAIL full_res[%0d] got %0d/%0d want 16383/16383", k, res_a, res_b); end
      checks++; if (conv_cnt - c0 !== 256) begin fails++; $display("FAIL full_convs[%0d] got %0d want 256", k, conv_cnt - c0); end
      consume();
    end
  endtask

  task automatic test_result_hold;
    bit ok;
    int c0;
    set_tables(5, 5, 5, 5, 7, 7, 7, 7);
    run_burst(4'd0, 200, ok);
    c0 = conv_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_busy got %b want 0", busy); end
    checks++; if (conv_cnt - c0 !== 0) begin fails++; $display("FAIL hold_convs got %0d want 0", conv_cnt - c0); end
    checks++; if ({res_valid, res_a, res_b} !== {1'b1, 14'd5, 14'd7}) begin fails++; $display("FAIL hold_res got v=%b %0d/%0d want v=1 5/7", res_valid, res_a, res_b); end
    set_tables(9, 9, 9, 9, 3, 3, 3, 3);
    consume();
    run_burst(4'd0, 200, ok);
    checks++; if ({ok, res_a, res_b} !== {1'b1, 14'd9, 14'd3}) begin fails++; $display("FAIL hold_next got ok=%b %0d/%0d want ok=1 9/3", ok, res_a, res_b); end
    consume();
  endtask

  task automatic test_timeout;
    int r0;
    int waited;
    bit seen;
    r0 = rst_cnt; seen = 1'b0; waited = 0;
    stuck = 1'b1;
    start = 1'b1; avg_shift = 4'd0;
    for (int n = 1; n <= 1200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (adc.cs && adc.op == OP_RST) begin seen = 1'b1; waited = n; break; end
    end
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL timeout_seen got %b want 1", seen); end
    checks++; if (waited < 1025 || waited > 1029) begin fails++; $display("FAIL timeout_cycles got %0d want about 1027", waited); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    stuck = 1'b0;
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_err got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_idle got busy=%b want 0", busy); end
    checks++; if (rst_cnt - r0 !== 1) begin fails++; $display("FAIL timeout_rstop got %0d want 1", rst_cnt - r0); end
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL timeout_valid got %b want 0", res_valid); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_clr got %b want 0", err); end
  endtask

  task automatic test_reset_midburst;
    bit seen;
    bit saw_valid;
    seen = 1'b0; saw_valid = 1'b0;
    set_tables(1, 2, 3, 4, 5, 6, 7, 8);
    start = 1'b1; avg_shift = 4'd2;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (adc.cs && adc.op == OP_CONV) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL mid_trig got %b want 1", seen); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, err, res_valid} !== 3'b000) begin fails++; $display("FAIL mid_flags got busy=%b err=%b valid=%b want 000", busy, err, res_valid); end
    checks++; if ({adc.cs, adc.op, adc.addr} !== 13'd0) begin fails++; $display("FAIL mid_adc got cs=%b op=%b addr=%0d want 0", adc.cs, adc.op, adc.addr); end
    checks++; if ({res_a, res_b} !== 28'd0) begin fails++; $display("FAIL mid_res got %0d/%0d want 0/0", res_a, res_b); end
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (res_valid || busy) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin fails++; $display("FAIL mid_noresult got activity=%b want 0", saw_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_average();
    test_full_scale();
    test_result_hold();
    test_timeout();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
